// File: rtl/led_status_gen.sv
// led_status_gen: PCIe front-panel status LED driver.
// Decodes PLL lock / LTSSM / data-link status into status LEDs and drives
// NUM_ACT activity LEDs, each with a per-channel mode and a fixed-length
// pulse stretcher. All LED outputs share one polarity control; act_busy is
// the raw stretcher state and is never inverted.
module led_status_gen #(
  parameter int NUM_ACT   = 4,
  parameter int STRETCH_W = 26,
  parameter int BLINK_W   = 24,
  parameter int LTSSM_W   = 4,
  parameter int POLL_CODE = 1,
  parameter int L0_CODE   = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   invert,
  input  logic                   lock,
  input  logic [LTSSM_W-1:0]     ltssm_state,
  input  logic                   dl_up_in,
  input  logic [NUM_ACT-1:0]     act_in,
  input  logic [2*NUM_ACT-1:0]   act_mode,
  input  logic                   clr_drop,
  output logic                   pll_lk,
  output logic                   poll,
  output logic                   l0,
  output logic                   dl_up_out,
  output logic                   link_drop,
  output logic [NUM_ACT-1:0]     act_led,
  output logic [NUM_ACT-1:0]     act_busy
);

  localparam logic [LTSSM_W-1:0] PollCode = LTSSM_W'(POLL_CODE);
  localparam logic [LTSSM_W-1:0] L0Code   = LTSSM_W'(L0_CODE);

  // Link status state
  logic poll_q, poll_d;
  logic l0_q, l0_d;
  logic dl_up_q, dl_up_d;
  logic drop_q, drop_d;

  // Blink prescaler
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               blink;

  // Per-channel stretchers
  logic [NUM_ACT-1:0]   busy_q, busy_d;
  logic [STRETCH_W-1:0] cnt_q [NUM_ACT];
  logic [STRETCH_W-1:0] cnt_d [NUM_ACT];

  // Pre-polarity activity LED values
  logic [NUM_ACT-1:0] act_raw;

  // Status latches: sticky poll, registered l0/dl_up, sticky drop where set beats clear
  always_comb begin
    poll_d  = poll_q | (ltssm_state == PollCode);
    l0_d    = (ltssm_state == L0Code);
    dl_up_d = dl_up_in;
    drop_d  = drop_q;
    if (clr_drop) begin
      drop_d = 1'b0;
    end
    if (l0_q && !l0_d) begin
      drop_d = 1'b1;
    end
  end

  // Free-running blink prescaler; its MSB is the blink phase
  always_comb begin
    blink_d = blink_q + BLINK_W'(1);
  end

  assign blink = blink_q[BLINK_W-1];

  // Stretchers: accept a strobe only when idle, then run a full wrap of cnt
  // (cnt goes 1..max,0) and drop busy on the edge after cnt has wrapped.
  always_comb begin
    for (int i = 0; i < NUM_ACT; i++) begin
      busy_d[i] = busy_q[i];
      cnt_d[i]  = cnt_q[i];
      if (!busy_q[i]) begin
        if (act_in[i]) begin
          busy_d[i] = 1'b1;
          cnt_d[i]  = STRETCH_W'(1);
        end
      end else if (cnt_q[i] == '0) begin
        busy_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_q[i] + STRETCH_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      poll_q  <= 1'b0;
      l0_q    <= 1'b0;
      dl_up_q <= 1'b0;
      drop_q  <= 1'b0;
      blink_q <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NUM_ACT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      poll_q  <= poll_d;
      l0_q    <= l0_d;
      dl_up_q <= dl_up_d;
      drop_q  <= drop_d;
      blink_q <= blink_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_ACT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-channel mode select; purely combinational so mode never touches the stretcher
  always_comb begin
    for (int i = 0; i < NUM_ACT; i++) begin
      case (act_mode[2*i +: 2])
        2'b00:   act_raw[i] = 1'b0;
        2'b01:   act_raw[i] = 1'b1;
        2'b10:   act_raw[i] = busy_q[i];
        default: act_raw[i] = busy_q[i] & blink;
      endcase
    end
  end

  // Output polarity applied to every LED; act_busy stays raw
  always_comb begin
    pll_lk    = lock    ^ invert;
    poll      = poll_q  ^ invert;
    l0        = l0_q    ^ invert;
    dl_up_out = dl_up_q ^ invert;
    link_drop = drop_q  ^ invert;
    act_led   = act_raw ^ {NUM_ACT{invert}};
    act_busy  = busy_q;
  end

endmodule

// File: tb/tb_led_status_gen.sv
// Directed testbench for led_status_gen (STRETCH_W=3, BLINK_W=2, NUM_ACT=4).
module tb_led_status_gen;

  logic       clk = 1'b0;
  logic       rstn, invert, lock, dl_up_in, clr_drop;
  logic [3:0] ltssm_state;
  logic [3:0] act_in;
  logic [7:0] act_mode;
  logic       pll_lk, poll, l0, dl_up_out, link_drop;
  logic [3:0] act_led, act_busy;

  int checks = 0;
  int failures = 0;

  // Blink phase reference: 2-bit counter from reset release, blink = bit 1
  logic [1:0] bc = 2'd0;

  led_status_gen #(
    .NUM_ACT(4), .STRETCH_W(3), .BLINK_W(2), .LTSSM_W(4),
    .POLL_CODE(1), .L0_CODE(3)
  ) dut (
    .clk(clk), .rstn(rstn), .invert(invert), .lock(lock),
    .ltssm_state(ltssm_state), .dl_up_in(dl_up_in), .act_in(act_in),
    .act_mode(act_mode), .clr_drop(clr_drop), .pll_lk(pll_lk), .poll(poll),
    .l0(l0), .dl_up_out(dl_up_out), .link_drop(link_drop),
    .act_led(act_led), .act_busy(act_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rstn) bc <= 2'd0;
    else       bc <= bc + 2'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; invert = 1'b0; lock = 1'b1; dl_up_in = 1'b0; clr_drop = 1'b0;
    ltssm_state = 4'd0; act_in = 4'h0; act_mode = 8'h55;
    step(); step();
    checks++;
    if (act_led !== 4'hF) begin failures++; $display("FAIL reset_act_led got=%h exp=F", act_led); end
    checks++;
    if ({poll, l0, dl_up_out, link_drop} !== 4'b0000) begin
      failures++; $display("FAIL reset_status got=%b exp=0000", {poll, l0, dl_up_out, link_drop});
    end
    checks++;
    if (act_busy !== 4'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", act_busy); end
    checks++;
    if (pll_lk !== 1'b1) begin failures++; $display("FAIL reset_pll_lk got=%b exp=1", pll_lk); end
    invert = 1'b1; #1;
    checks++;
    if (act_led !== 4'h0) begin failures++; $display("FAIL inv_act_led got=%h exp=0", act_led); end
    checks++;
    if ({poll, l0, dl_up_out, link_drop} !== 4'b1111) begin
      failures++; $display("FAIL inv_status got=%b exp=1111", {poll, l0, dl_up_out, link_drop});
    end
    checks++;
    if (pll_lk !== 1'b0) begin failures++; $display("FAIL inv_pll_lk_locked got=%b exp=0", pll_lk); end
    lock = 1'b0; #1;
    checks++;
    if (pll_lk !== 1'b1) begin failures++; $display("FAIL inv_pll_lk_unlocked got=%b exp=1", pll_lk); end
    checks++;
    if (act_busy !== 4'h0) begin failures++; $display("FAIL inv_busy got=%h exp=0", act_busy); end
    invert = 1'b0; lock = 1'b1;
  endtask

  task automatic test_poll();
    int bad;
    rstn = 1'b1; step();
    ltssm_state = 4'd1; step();
    ltssm_state = 4'd0;
    checks++;
    if (poll !== 1'b1) begin failures++; $display("FAIL poll_set got=%b exp=1", poll); end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (poll !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL poll_sticky low_cycles=%0d exp=0", bad); end
    rstn = 1'b0; step();
    checks++;
    if (poll !== 1'b0) begin failures++; $display("FAIL poll_reset got=%b exp=0", poll); end
    rstn = 1'b1; step();
  endtask

  task automatic test_dl_up();
    dl_up_in = 1'b1; #1;
    checks++;
    if (dl_up_out !== 1'b0) begin failures++; $display("FAIL dl_up_latency got=%b exp=0", dl_up_out); end
    step();
    checks++;
    if (dl_up_out !== 1'b1) begin failures++; $display("FAIL dl_up_set got=%b exp=1", dl_up_out); end
    dl_up_in = 1'b0; step();
    checks++;
    if (dl_up_out !== 1'b0) begin failures++; $display("FAIL dl_up_clr got=%b exp=0", dl_up_out); end
  endtask

  task automatic test_l0_drop();
    int bad;
    ltssm_state = 4'd3; #1;
    checks++;
    if (l0 !== 1'b0) begin failures++; $display("FAIL l0_latency got=%b exp=0", l0); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (l0 !== 1'b1 || link_drop !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL l0_high bad_cycles=%0d exp=0", bad); end
    ltssm_state = 4'd2; step();
    checks++;
    if ({l0, link_drop} !== 2'b01) begin failures++; $display("FAIL l0_drop got=%b exp=01", {l0, link_drop}); end
    step();
    checks++;
    if (link_drop !== 1'b1) begin failures++; $display("FAIL drop_sticky got=%b exp=1", link_drop); end
    clr_drop = 1'b1; step(); clr_drop = 1'b0;
    checks++;
    if (link_drop !== 1'b0) begin failures++; $display("FAIL drop_clear got=%b exp=0", link_drop); end
    ltssm_state = 4'd3; step(); step();
    ltssm_state = 4'd2; clr_drop = 1'b1; step(); clr_drop = 1'b0;
    checks++;
    if (link_drop !== 1'b1) begin failures++; $display("FAIL drop_set_wins got=%b exp=1", link_drop); end
    clr_drop = 1'b1; step(); clr_drop = 1'b0;
    checks++;
    if (link_drop !== 1'b0) begin failures++; $display("FAIL drop_clear2 got=%b exp=0", link_drop); end
    ltssm_state = 4'd0;
  endtask

  task automatic test_stretch();
    int bad;
    logic e;
    act_mode = 8'h02;
    act_in = 4'h1; step(); act_in = 4'h0;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      e = (k <= 8);
      if (act_led[0] !== e || act_busy[0] !== e) begin
        bad++; $display("FAIL stretch_single obs=%0d led=%b busy=%b exp=%b", k, act_led[0], act_busy[0], e);
      end
      if (k == 3) act_in = 4'h1;
      if (k == 4) act_in = 4'h0;
      if (k < 10) step();
    end
    checks++;
    if (bad != 0) failures++;
    act_in = 4'h1; step();
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      e = (k != 9 && k != 18);
      if (act_busy[0] !== e || act_led[0] !== e) begin
        bad++; $display("FAIL stretch_held obs=%0d busy=%b exp=%b", k, act_busy[0], e);
      end
      if (k == 18) act_in = 4'h0;
      else step();
    end
    checks++;
    if (bad != 0) failures++;
    step();
    checks++;
    if (act_busy !== 4'h0) begin failures++; $display("FAIL stretch_idle got=%h exp=0", act_busy); end
  endtask

  task automatic test_blink();
    int bad;
    logic e;
    int seen_hi, seen_lo;
    act_mode = 8'h0C;
    act_in = 4'h2; step(); act_in = 4'h0;
    bad = 0; seen_hi = 0; seen_lo = 0;
    for (int k = 1; k <= 9; k++) begin
      e = (k <= 8) & bc[1];
      if (k <= 8) begin
        if (bc[1]) seen_hi++; else seen_lo++;
      end
      if (act_led[1] !== e || act_busy[1] !== (k <= 8)) begin
        bad++; $display("FAIL blink obs=%0d led=%b busy=%b exp_led=%b", k, act_led[1], act_busy[1], e);
      end
      if (k < 9) step();
    end
    checks++;
    if (bad != 0 || seen_hi != 4 || seen_lo != 4) begin
      failures++; $display("FAIL blink_pattern bad=%0d hi=%0d lo=%0d exp=0/4/4", bad, seen_hi, seen_lo);
    end
    act_in = 4'h2; step(); act_in = 4'h0;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin act_mode = 8'h00; #1; end
      e = (k < 3) & bc[1];
      if (act_led[1] !== e || act_busy[1] !== (k <= 8)) begin
        bad++; $display("FAIL mode_off obs=%0d led=%b busy=%b exp_led=%b", k, act_led[1], act_busy[1], e);
      end
      if (k < 9) step();
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic test_reset_mid();
    int bad;
    logic e;
    act_mode = 8'h02;
    act_in = 4'h1; step(); act_in = 4'h0;
    step(); step(); step();
    checks++;
    if (act_busy[0] !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", act_busy[0]); end
    rstn = 1'b0; step();
    checks++;
    if (act_busy[0] !== 1'b0 || act_led[0] !== 1'b0) begin
      failures++; $display("FAIL mid_reset busy=%b led=%b exp=0/0", act_busy[0], act_led[0]);
    end
    invert = 1'b1; #1;
    checks++;
    if (act_led !== 4'hF) begin failures++; $display("FAIL mid_reset_inv got=%h exp=F", act_led); end
    invert = 1'b0; rstn = 1'b1;
    act_in = 4'h1; step(); act_in = 4'h0;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      e = (k <= 8);
      if (act_busy[0] !== e || act_led[0] !== e) begin
        bad++; $display("FAIL restretch obs=%0d busy=%b exp=%b", k, act_busy[0], e);
      end
      if (k < 9) step();
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  initial begin
    test_reset();
    test_poll();
    test_dl_up();
    test_l0_drop();
    test_stretch();
    test_blink();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
